// File: rtl/serial_char_rx_if.sv
// Signal bundle between the serial character receiver and its consumer.
// The receiver uses the slave view (line in, character and status out);
// whatever drives the line and consumes characters uses the master view.
interface serial_char_rx_if;
  logic       rx;
  logic [7:0] char_out;
  logic       char_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  modport slave (
    input  rx,
    output char_out,
    output char_valid,
    output frame_err,
    output parity_err,
    output busy
  );

  modport master (
    output rx,
    input  char_out,
    input  char_valid,
    input  frame_err,
    input  parity_err,
    input  busy
  );
endinterface

// File: rtl/serial_char_rx.sv
// Serial character receiver: 8N1 by default, 8E1 when SERIAL_RX_PARITY_EN is
// defined. Deserializes the async line into bytes, presents each good byte
// as a held character with a one-cycle char_valid strobe, and reports
// framing/parity errors without disturbing the held character.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | line idle, waiting for a synchronized falling edge
// START     | timing to mid start bit; high there means a glitch
// DATA      | sampling 8 data bits LSB first, one per bit period
// PARITY    | sampling the even-parity bit (SERIAL_RX_PARITY_EN only)
// STOP      | sampling the stop bit and issuing the result strobe
// WAIT_HIGH | stop bit was low (framing error/break); wait for line high
module serial_char_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic            clk,
  input  logic            reset,
  serial_char_rx_if.slave bus
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_TC = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_TC = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef SERIAL_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_t;

  state_t        state;
  state_t        state_next;
  logic          rx_meta;
  logic          rx_s;
  logic [TW-1:0] timer;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic [7:0]    char_q;
  logic          char_valid_q;
  logic          frame_err_q;

  logic          timer_clr;
  logic          shift_en;
  logic          char_load;
  logic          frame_set;

`ifdef SERIAL_RX_PARITY_EN
  logic          par_bad;
  logic          par_load;
  logic          parity_set;
  logic          parity_err_q;
`endif

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode and per-cycle datapath controls.
  always_comb begin
    state_next = state;
    timer_clr  = 1'b0;
    shift_en   = 1'b0;
    char_load  = 1'b0;
    frame_set  = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    par_load   = 1'b0;
    parity_set = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          timer_clr  = 1'b1;
        end
      end
      START: begin
        if (timer == HALF_TC) begin
          timer_clr  = 1'b1;
          state_next = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (timer == FULL_TC) begin
          timer_clr = 1'b1;
          shift_en  = 1'b1;
          if (bit_cnt == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef SERIAL_RX_PARITY_EN
      PARITY: begin
        if (timer == FULL_TC) begin
          timer_clr  = 1'b1;
          par_load   = 1'b1;
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (timer == FULL_TC) begin
          timer_clr = 1'b1;
          if (rx_s) begin
            state_next = IDLE;
`ifdef SERIAL_RX_PARITY_EN
            if (par_bad) parity_set = 1'b1;
            else         char_load  = 1'b1;
`else
            char_load = 1'b1;
`endif
          end else begin
            // Framing error wins over any parity mismatch.
            frame_set  = 1'b1;
            state_next = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_s) begin
          timer_clr  = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        timer_clr  = 1'b1;
      end
    endcase
  end

  // Bit timer and data bit counter; counter wraps 7->0 as DATA exits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer   <= '0;
      bit_cnt <= '0;
    end else begin
      if (timer_clr) timer <= '0;
      else           timer <= timer + TW'(1);
      if (shift_en)  bit_cnt <= bit_cnt + 3'd1;
    end
  end

  // LSB-first shift register; new bits enter at the MSB end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         shift <= 8'h00;
    else if (shift_en) shift <= {rx_s, shift[7:1]};
  end

  // Held character and one-cycle result strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      char_q       <= 8'h20;
      char_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      char_valid_q <= char_load;
      frame_err_q  <= frame_set;
      if (char_load) char_q <= shift;
    end
  end

`ifdef SERIAL_RX_PARITY_EN
  // Even-parity mismatch flag captured at the parity mid-bit, plus its strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_bad      <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_set;
      if (par_load) par_bad <= (^shift) ^ rx_s;
    end
  end

  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.char_out   = char_q;
  assign bus.char_valid = char_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_serial_char_rx.sv
// Bench for serial_char_rx at CLKS_PER_BIT=4. The driver pushes the expected
// outcome of each frame (char, framing error or parity error, plus the
// nominal strobe cycle) into a queue; a monitor on the falling clock edge
// pops and compares whenever a strobe appears, and checks that char_out
// holds its value between good characters.
module tb_serial_char_rx;

  localparam int CPB = 4;
`ifdef SERIAL_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  // Cycles from the posedge after which rx falls to the visible strobe.
  localparam int LAT = 3 + CPB / 2 + 9 * CPB + (PAR ? CPB : 0);

  typedef enum int {EV_CHAR = 0, EV_FRAME = 1, EV_PARITY = 2} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  ev_t        exp_q[$];
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  int         cyc = 0;
  int         compared = 0;
  int         mismatched = 0;
  int         n_valid = 0;
  logic [7:0] exp_char = 8'h20;

  ev_t        mon_e;
  int         mon_nstrb;
  int         mon_kind;
  int         mon_dt;

  serial_char_rx_if bus();

  serial_char_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop, input bit pflip);
    ev_t e;
    e.data = d;
    e.cyc  = cyc;
    if (!stop)             e.kind = EV_FRAME;
    else if (PAR && pflip) e.kind = EV_PARITY;
    else                   e.kind = EV_CHAR;
    exp_q.push_back(e);
    bus.rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      tick(CPB);
    end
    if (PAR) begin
      bus.rx = (^d) ^ pflip;
      tick(CPB);
    end
    bus.rx = stop;
    tick(CPB);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      tick(1);
      n++;
    end
    tick(4);
    check("queue_drained", exp_q.size(), 0);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (reset) begin
      exp_char = 8'h20;
    end else begin
      mon_nstrb = int'(bus.char_valid) + int'(bus.frame_err) + int'(bus.parity_err);
      if (mon_nstrb > 1) check("single_strobe", mon_nstrb, 1);
      if (mon_nstrb != 0) begin
        if (bus.char_valid) n_valid++;
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_strobe: valid=%0b frame=%0b parity=%0b with nothing expected at cycle %0d",
                   bus.char_valid, bus.frame_err, bus.parity_err, cyc);
        end else begin
          mon_e    = exp_q.pop_front();
          mon_kind = bus.char_valid ? int'(EV_CHAR) : (bus.frame_err ? int'(EV_FRAME) : int'(EV_PARITY));
          check("strobe_kind", mon_kind, int'(mon_e.kind));
          mon_dt = cyc - mon_e.cyc;
          compared++;
          if (mon_dt < LAT - 1 || mon_dt > LAT + 1) begin
            mismatched++;
            $display("FAIL strobe_latency: got %0d cycles expected %0d +/-1", mon_dt, LAT);
          end
          if (mon_e.kind == EV_CHAR) begin
            check("char_out", bus.char_out, mon_e.data);
            exp_char = mon_e.data;
          end
        end
      end
      if (!bus.char_valid) check("char_hold", bus.char_out, exp_char);
`ifndef SERIAL_RX_PARITY_EN
      check("parity_tied", bus.parity_err, 0);
`endif
    end
  end

  logic [7:0] begin_str [6] = '{8'h62, 8'h65, 8'h67, 8'h69, 8'h6E, 8'h20};

  initial begin
    int n0;
    logic [7:0] d;
    bit stop;
    bit pflip;

    bus.rx = 1'b1;
    reset  = 1'b1;
    tick(3);
    @(negedge clk);
    check("rst_char_out", bus.char_out, 8'h20);
    check("rst_char_valid", bus.char_valid, 0);
    check("rst_frame_err", bus.frame_err, 0);
    check("rst_parity_err", bus.parity_err, 0);
    check("rst_busy", bus.busy, 0);
    tick(1);
    reset = 1'b0;

    // Idle line after reset.
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      check("idle_busy", bus.busy, 0);
      check("idle_strobes", {bus.char_valid, bus.frame_err, bus.parity_err}, 0);
    end
    tick(1);

    // "begin " back-to-back.
    n0 = n_valid;
    foreach (begin_str[i]) send_frame(begin_str[i], 1'b1, 1'b0);
    drain();
    check("begin_valid_count", n_valid - n0, 6);

    // Framing error, break, then a good frame.
    n0 = n_valid;
    send_frame(8'h41, 1'b0, 1'b0);
    tick(20);
    bus.rx = 1'b1;
    tick(2 * CPB);
    send_frame(8'h5A, 1'b1, 1'b0);
    drain();
    check("frame_err_valid_count", n_valid - n0, 1);

    // One-cycle glitch.
    bus.rx = 1'b0;
    tick(1);
    bus.rx = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("glitch_busy_low", bus.busy, 0);
    tick(2 * CPB);
    check("glitch_no_event", exp_q.size(), 0);

    // Reset during data bit 4 of 8'hFF.
    n0 = n_valid;
    bus.rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      bus.rx = 1'b1;
      tick(CPB);
    end
    tick(1);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", bus.busy, 0);
    check("abort_char_out", bus.char_out, 8'h20);
    tick(5 * CPB);
    send_frame(8'h64, 1'b1, 1'b0);
    drain();
    check("abort_valid_count", n_valid - n0, 1);

`ifdef SERIAL_RX_PARITY_EN
    // Bad then good parity on 8'h45.
    n0 = n_valid;
    send_frame(8'h45, 1'b1, 1'b1);
    tick(CPB);
    send_frame(8'h45, 1'b1, 1'b0);
    drain();
    check("parity_valid_count", n_valid - n0, 1);
`endif

    // Randomized frames with occasional framing/parity errors and gaps.
    for (int k = 0; k < 40; k++) begin
      d     = 8'($urandom_range(0, 255));
      stop  = ($urandom_range(0, 7) != 0);
      pflip = ($urandom_range(0, 5) == 0);
      send_frame(d, stop, pflip);
      if (!stop) begin
        tick($urandom_range(0, 10) + 1);
        bus.rx = 1'b1;
        tick(CPB * $urandom_range(1, 3));
      end else if ($urandom_range(0, 2) != 0) begin
        tick(CPB * $urandom_range(1, 2));
      end
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
